axi_rd_arbiter: RTL and testbench

- Shares the single AXI4 read channel of the memory bus between two read masters: master 0 (instruction cache refill) and master 1 (load/store unit).
- Only one transaction is outstanding at a time. A grant is held from AR issue through the final R beat (rlast).
- Sits between the IFU/LSU read ports and the bus crossbar/SoC read port.
- Also checks burst beat count against the granted arlen and runs an optional transaction watchdog.

---
 rtl/axi_rd_arbiter_pkg.sv | 32 +++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/axi_rd_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI4 read arbiter.
//   - FSM state encoding (IDLE / AR / R)
//   - AXI field widths and response codes
//   - AR request bundle used to mux the two masters onto the slave port
package axi_rd_arbiter_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [ID_W-1:0]    id;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selector.
//   req_i        : request from master 0 (bit 0) and master 1 (bit 1)
//   last_grant_i : master that won the previous issued transaction
//   grant_o      : index of the winning master (only meaningful if |req_i)
// RR=1 alternates on ties; RR=0 gives master 1 fixed priority on ties.
module rr_arbiter2 #(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o
);

    always_comb begin
        grant_o = 1'b0;
        if (req_i == 2'b11) begin
            grant_o = RR ? ~last_grant_i : 1'b1;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between master 0 (icache refill) and
// master 1 (LSU). One transaction outstanding; the grant is held from AR
// issue through the rlast beat, followed by one mandatory IDLE cycle.
//
// Ports:
//   i_clock, i_reset_n          : clock, async active-low reset
//   i_mX_ar*, o_mX_arready      : master X read address channel
//   o_mX_r*, i_mX_rready        : master X read data channel
//   o_s_ar*, i_s_arready        : slave read address channel
//   i_s_r*, o_s_rready          : slave read data channel
//   o_busy    : FSM not in IDLE
//   o_grant   : granted master index (0 outside a transaction)
//   o_len_err : one-cycle pulse, cycle after a beat that disagrees with arlen
//   o_timeout : sticky watchdog flag (AR/R stalled TIMEOUT cycles)
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               i_clock,
    input  logic               i_reset_n,

    input  logic [ADDR_W-1:0]  i_m0_araddr,
    input  logic               i_m0_arvalid,
    input  logic [ID_W-1:0]    i_m0_arid,
    input  logic [LEN_W-1:0]   i_m0_arlen,
    input  logic [SIZE_W-1:0]  i_m0_arsize,
    input  logic [BURST_W-1:0] i_m0_arburst,
    output logic               o_m0_arready,
    output logic [DATA_W-1:0]  o_m0_rdata,
    output logic               o_m0_rvalid,
    output logic [RESP_W-1:0]  o_m0_rresp,
    output logic [ID_W-1:0]    o_m0_rid,
    output logic               o_m0_rlast,
    input  logic               i_m0_rready,

    input  logic [ADDR_W-1:0]  i_m1_araddr,
    input  logic               i_m1_arvalid,
    input  logic [ID_W-1:0]    i_m1_arid,
    input  logic [LEN_W-1:0]   i_m1_arlen,
    input  logic [SIZE_W-1:0]  i_m1_arsize,
    input  logic [BURST_W-1:0] i_m1_arburst,
    output logic               o_m1_arready,
    output logic [DATA_W-1:0]  o_m1_rdata,
    output logic               o_m1_rvalid,
    output logic [RESP_W-1:0]  o_m1_rresp,
    output logic [ID_W-1:0]    o_m1_rid,
    output logic               o_m1_rlast,
    input  logic               i_m1_rready,

    output logic [ADDR_W-1:0]  o_s_araddr,
    output logic               o_s_arvalid,
    output logic [ID_W-1:0]    o_s_arid,
    output logic [LEN_W-1:0]   o_s_arlen,
    output logic [SIZE_W-1:0]  o_s_arsize,
    output logic [BURST_W-1:0] o_s_arburst,
    input  logic               i_s_arready,
    input  logic [DATA_W-1:0]  i_s_rdata,
    input  logic               i_s_rvalid,
    input  logic [RESP_W-1:0]  i_s_rresp,
    input  logic [ID_W-1:0]    i_s_rid,
    input  logic               i_s_rlast,
    output logic               o_s_rready,

    output logic               o_busy,
    output logic               o_grant,
    output logic               o_len_err,
    output logic               o_timeout
);

    // Watchdog counter is sized to hold TIMEOUT; a disabled watchdog keeps 1 bit.
    localparam int unsigned     WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
    logic               len_err_q, len_err_d;

    ar_req_t [1:0]      m_ar;
    logic    [1:0]      m_arvalid;
    logic    [1:0]      m_rready;
    ar_req_t            s_ar;
    logic    [1:0]      ar_ready;
    logic    [1:0]      r_sel;
    logic               arb_gnt;
    logic               ar_hs;
    logic               r_beat;

    assign m_ar[0] = '{addr: i_m0_araddr, id: i_m0_arid, len: i_m0_arlen,
                       size: i_m0_arsize, burst: i_m0_arburst};
    assign m_ar[1] = '{addr: i_m1_araddr, id: i_m1_arid, len: i_m1_arlen,
                       size: i_m1_arsize, burst: i_m1_arburst};
    assign m_arvalid = {i_m1_arvalid, i_m0_arvalid};
    assign m_rready  = {i_m1_rready, i_m0_rready};

    rr_arbiter2 #(
        .RR (RR != 0)
    ) u_arb (
        .req_i        (m_arvalid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_gnt)
    );

    // ------------------------------------------------------------------
    // Channel muxing: everything toward a master or the slave is zero
    // unless the FSM is in the phase that owns that channel.
    // ------------------------------------------------------------------
    always_comb begin
        s_ar        = '0;
        o_s_arvalid = 1'b0;
        ar_ready    = 2'b00;
        r_sel       = 2'b00;
        o_s_rready  = 1'b0;
        if (state_q == ST_AR) begin
            s_ar              = m_ar[grant_q];
            o_s_arvalid       = m_arvalid[grant_q];
            ar_ready[grant_q] = i_s_arready;
        end
        if (state_q == ST_R) begin
            r_sel[grant_q] = 1'b1;
            o_s_rready     = m_rready[grant_q];
        end
    end

    assign o_s_araddr  = s_ar.addr;
    assign o_s_arid    = s_ar.id;
    assign o_s_arlen   = s_ar.len;
    assign o_s_arsize  = s_ar.size;
    assign o_s_arburst = s_ar.burst;

    assign o_m0_arready = ar_ready[0];
    assign o_m1_arready = ar_ready[1];

    assign o_m0_rvalid = r_sel[0] & i_s_rvalid;
    assign o_m0_rdata  = r_sel[0] ? i_s_rdata : '0;
    assign o_m0_rresp  = r_sel[0] ? i_s_rresp : '0;
    assign o_m0_rid    = r_sel[0] ? i_s_rid   : '0;
    assign o_m0_rlast  = r_sel[0] & i_s_rlast;

    assign o_m1_rvalid = r_sel[1] & i_s_rvalid;
    assign o_m1_rdata  = r_sel[1] ? i_s_rdata : '0;
    assign o_m1_rresp  = r_sel[1] ? i_s_rresp : '0;
    assign o_m1_rid    = r_sel[1] ? i_s_rid   : '0;
    assign o_m1_rlast  = r_sel[1] & i_s_rlast;

    assign ar_hs  = o_s_arvalid & i_s_arready;
    assign r_beat = i_s_rvalid & o_s_rready;

    // ------------------------------------------------------------------
    // FSM, grant tracking and beat counting
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        beat_d       = beat_q;
        len_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|m_arvalid) begin
                    grant_d = arb_gnt;
                    len_d   = m_ar[arb_gnt].len;
                    beat_d  = '0;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                // A master withdrawing arvalid before acceptance is a protocol
                // violation; drop the grant rather than issue a stale request.
                if (!m_arvalid[grant_q]) begin
                    state_d = ST_IDLE;
                end else if (i_s_arready) begin
                    state_d      = ST_R;
                    last_grant_d = grant_q;
                end
            end
            ST_R: begin
                if (r_beat) begin
                    if (beat_q != 8'hFF) begin
                        beat_d = beat_q + 8'd1;
                    end
                    // beat_q is the zero-based index of the current beat, so the
                    // rlast beat must carry index len_q.
                    if (i_s_rlast) begin
                        state_d   = ST_IDLE;
                        len_err_d = (beat_q != len_q);
                    end else begin
                        len_err_d = (beat_q == len_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog: counts stalled AR/R cycles, restarts on any handshake.
    // The flag is set on the edge where the count reaches TIMEOUT.
    // ------------------------------------------------------------------
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (state_q == ST_IDLE || state_d == ST_IDLE || ar_hs || r_beat) begin
            wdog_d = '0;
        end else if (wdog_q != WD_MAX) begin
            wdog_d = wdog_q + WD_W'(1);
        end
        if (TIMEOUT != 0 && wdog_d == WD_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            len_q        <= '0;
            beat_q       <= '0;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
            len_err_q    <= len_err_d;
        end
    end

    assign o_busy    = (state_q != ST_IDLE);
    assign o_grant   = o_busy & grant_q;
    assign o_len_err = len_err_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter. Main instance: RR=1, TIMEOUT=16. A second
// instance (RR=0, watchdog off) shares every input and runs in lockstep;
// only its grants and idle/timeout outputs are checked.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arvalid, m1_arvalid;
    logic [3:0]  m0_arid, m1_arid;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_rready, m1_rready;
    logic        s_arready, s_rvalid, s_rlast;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [3:0]  s_rid;

    logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [31:0] m0_rdata, m1_rdata, s_araddr;
    logic [1:0]  m0_rresp, m1_rresp, s_arburst;
    logic [3:0]  m0_rid, m1_rid, s_arid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic        s_arvalid, s_rready, busy, grant, len_err, timeout;

    logic        f_m0_arready, f_m1_arready, f_m0_rvalid, f_m1_rvalid, f_m0_rlast, f_m1_rlast;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
    logic [1:0]  f_m0_rresp, f_m1_rresp, f_s_arburst;
    logic [3:0]  f_m0_rid, f_m1_rid, f_s_arid;
    logic [7:0]  f_s_arlen;
    logic [2:0]  f_s_arsize;
    logic        f_s_arvalid, f_s_rready, f_busy, f_grant, f_len_err, f_timeout;

    axi_rd_arbiter #(.RR(1), .TIMEOUT(16)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_m0_araddr(m0_araddr), .i_m0_arvalid(m0_arvalid), .i_m0_arid(m0_arid),
        .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .i_m0_arburst(m0_arburst),
        .o_m0_arready(m0_arready), .o_m0_rdata(m0_rdata), .o_m0_rvalid(m0_rvalid),
        .o_m0_rresp(m0_rresp), .o_m0_rid(m0_rid), .o_m0_rlast(m0_rlast), .i_m0_rready(m0_rready),
        .i_m1_araddr(m1_araddr), .i_m1_arvalid(m1_arvalid), .i_m1_arid(m1_arid),
        .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .i_m1_arburst(m1_arburst),
        .o_m1_arready(m1_arready), .o_m1_rdata(m1_rdata), .o_m1_rvalid(m1_rvalid),
        .o_m1_rresp(m1_rresp), .o_m1_rid(m1_rid), .o_m1_rlast(m1_rlast), .i_m1_rready(m1_rready),
        .o_s_araddr(s_araddr), .o_s_arvalid(s_arvalid), .o_s_arid(s_arid), .o_s_arlen(s_arlen),
        .o_s_arsize(s_arsize), .o_s_arburst(s_arburst), .i_s_arready(s_arready),
        .i_s_rdata(s_rdata), .i_s_rvalid(s_rvalid), .i_s_rresp(s_rresp), .i_s_rid(s_rid),
        .i_s_rlast(s_rlast), .o_s_rready(s_rready),
        .o_busy(busy), .o_grant(grant), .o_len_err(len_err), .o_timeout(timeout)
    );

    axi_rd_arbiter #(.RR(0), .TIMEOUT(0)) dut_fp (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_m0_araddr(m0_araddr), .i_m0_arvalid(m0_arvalid), .i_m0_arid(m0_arid),
        .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .i_m0_arburst(m0_arburst),
        .o_m0_arready(f_m0_arready), .o_m0_rdata(f_m0_rdata), .o_m0_rvalid(f_m0_rvalid),
        .o_m0_rresp(f_m0_rresp), .o_m0_rid(f_m0_rid), .o_m0_rlast(f_m0_rlast), .i_m0_rready(m0_rready),
        .i_m1_araddr(m1_araddr), .i_m1_arvalid(m1_arvalid), .i_m1_arid(m1_arid),
        .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .i_m1_arburst(m1_arburst),
        .o_m1_arready(f_m1_arready), .o_m1_rdata(f_m1_rdata), .o_m1_rvalid(f_m1_rvalid),
        .o_m1_rresp(f_m1_rresp), .o_m1_rid(f_m1_rid), .o_m1_rlast(f_m1_rlast), .i_m1_rready(m1_rready),
        .o_s_araddr(f_s_araddr), .o_s_arvalid(f_s_arvalid), .o_s_arid(f_s_arid), .o_s_arlen(f_s_arlen),
        .o_s_arsize(f_s_arsize), .o_s_arburst(f_s_arburst), .i_s_arready(s_arready),
        .i_s_rdata(s_rdata), .i_s_rvalid(s_rvalid), .i_s_rresp(s_rresp), .i_s_rid(s_rid),
        .i_s_rlast(s_rlast), .o_s_rready(f_s_rready),
        .o_busy(f_busy), .o_grant(f_grant), .o_len_err(f_len_err), .o_timeout(f_timeout)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; logic grant; } ar_exp_t;
    typedef struct { logic m; logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last; } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    logic    fg_q[$];
    int total = 0;
    int bad = 0;
    int lerr_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic beat_chk(input int m, input logic [31:0] d, input logic [1:0] rs,
                            input logic [3:0] id, input logic lst);
        r_exp_t e;
        if (r_q.size() == 0) begin
            total++; bad++;
            $display("FAIL r_unexpected: got beat on m%0d data %h want none", m, d);
            return;
        end
        e = r_q.pop_front();
        chk("r_master", 32'(m), 32'(e.m));
        chk("r_data", d, e.data);
        chk("r_resp", 32'(rs), 32'(e.resp));
        chk("r_id", 32'(id), 32'(e.id));
        chk("r_last", 32'(lst), 32'(e.last));
    endtask

    // Monitor: pops expectations whenever a handshake shows up on the DUT.
    always @(negedge clk) begin
        ar_exp_t e;
        if (len_err) lerr_cnt++;
        if (s_arvalid && s_arready) begin
            if (ar_q.size() == 0) begin
                total++; bad++;
                $display("FAIL ar_unexpected: got addr %h want none", s_araddr);
            end else begin
                e = ar_q.pop_front();
                chk("ar_addr", s_araddr, e.addr);
                chk("ar_len", 32'(s_arlen), 32'(e.len));
                chk("ar_id", 32'(s_arid), 32'(e.id));
                chk("ar_size", 32'(s_arsize), 32'd2);
                chk("ar_burst", 32'(s_arburst), 32'd1);
                chk("ar_grant", 32'(grant), 32'(e.grant));
            end
        end
        if (f_s_arvalid && s_arready) begin
            if (fg_q.size() == 0) begin
                total++; bad++;
                $display("FAIL fp_unexpected: got grant %0d want none", f_grant);
            end else begin
                chk("fp_grant", 32'(f_grant), 32'(fg_q.pop_front()));
            end
        end
        if (m0_rvalid && m0_rready) beat_chk(0, m0_rdata, m0_rresp, m0_rid, m0_rlast);
        if (m1_rvalid && m1_rready) beat_chk(1, m1_rdata, m1_rresp, m1_rid, m1_rlast);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic req(input int m, input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
        if (m == 0) begin
            m0_araddr = a; m0_arlen = len; m0_arid = id; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = a; m1_arlen = len; m1_arid = id; m1_arvalid = 1'b1;
        end
    endtask

    task automatic push_ar(input logic g, input logic [31:0] a, input logic [7:0] len,
                           input logic [3:0] id, input logic fg);
        ar_exp_t e;
        e.addr = a; e.len = len; e.id = id; e.grant = g;
        ar_q.push_back(e);
        fg_q.push_back(fg);
    endtask

    task automatic set_rready(input int m, input logic v);
        if (m == 0) m0_rready = v; else m1_rready = v;
    endtask

    // Returns in the first R cycle (just after the AR handshake edge).
    task automatic wait_ar();
        int n = 0;
        @(negedge clk);
        while (!(s_arvalid && s_arready) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL ar_wait: got no handshake want handshake within 50 cycles");
        end
        @(posedge clk); #1;
    endtask

    // Slave drives n beats; stall[i] holds the master's rready low for one
    // cycle before beat i is taken.
    task automatic beats(input int m, input int n, input logic [31:0] d0, input int last_at,
                         input logic [7:0] stall, input logic [3:0] id);
        r_exp_t e;
        for (int i = 0; i < n; i++) begin
            s_rvalid = 1'b1; s_rdata = d0 + 32'(i); s_rlast = (i == last_at);
            s_rid = id; s_rresp = RESP_OKAY;
            if (stall[i]) begin
                set_rready(m, 1'b0);
                step();
                set_rready(m, 1'b1);
            end
            e.m = m[0]; e.data = s_rdata; e.resp = RESP_OKAY; e.id = id; e.last = s_rlast;
            r_q.push_back(e);
            step();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    initial begin
        int base;
        m0_araddr = '0; m0_arvalid = 0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1;
        m1_araddr = '0; m1_arvalid = 0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'd1;
        m0_rready = 1; m1_rready = 1;
        s_arready = 1; s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rresp = '0; s_rid = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_arvalid", 32'(s_arvalid), 0);
        chk("rst_s_rready", 32'(s_rready), 0);
        chk("rst_len_err", 32'(len_err), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step();

        // Stray slave rvalid in IDLE is not accepted or forwarded
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("stray_s_rready", 32'(s_rready), 0);
        chk("stray_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
        step();
        s_rvalid = 1'b0;

        // Master withdraws arvalid before acceptance: grant dropped, nothing issued
        s_arready = 1'b0;
        req(0, 32'h0000_0040, 8'd0, 4'h7);
        step();
        @(negedge clk);
        chk("abandon_ar_arvalid", 32'(s_arvalid), 1);
        chk("abandon_ar_arready", 32'(m0_arready), 0);
        step();
        m0_arvalid = 1'b0;
        step();
        @(negedge clk);
        chk("abandon_idle", 32'({busy, s_arvalid}), 0);
        s_arready = 1'b1;
        step();

        // Single-beat LSU read, arbitration latency one cycle
        base = lerr_cnt;
        push_ar(1, 32'h8000_0010, 8'd0, 4'h3, 1);
        req(1, 32'h8000_0010, 8'd0, 4'h3);
        @(negedge clk);
        chk("t1_lat_cycleN", 32'(s_arvalid), 0);
        @(negedge clk);
        chk("t1_lat_cycleN1", 32'(s_arvalid), 1);
        chk("t1_arready", 32'({m1_arready, m0_arready}), 32'b10);
        @(posedge clk); #1;
        m1_arvalid = 1'b0;
        beats(1, 1, 32'hDEAD_BEEF, 0, 8'h00, 4'h3);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 0);
        step(); step();
        chk("t1_len_err", 32'(lerr_cnt - base), 0);

        // ICache 4-beat burst with rready stalls on beats 0 and 2
        base = lerr_cnt;
        push_ar(0, 32'h3000_0000, 8'd3, 4'h1, 0);
        req(0, 32'h3000_0000, 8'd3, 4'h1);
        wait_ar();
        m0_arvalid = 1'b0;
        chk("t2_busy_in_r", 32'(busy), 1);
        beats(0, 4, 32'hA000_0000, 3, 8'b0000_0101, 4'h1);
        @(negedge clk);
        chk("t2_busy_drop", 32'(busy), 0);
        step(); step();
        chk("t2_len_err", 32'(lerr_cnt - base), 0);

        // Early rlast: arlen=1, rlast on first beat -> one pulse
        base = lerr_cnt;
        push_ar(0, 32'h3000_0040, 8'd1, 4'h2, 0);
        req(0, 32'h3000_0040, 8'd1, 4'h2);
        wait_ar();
        m0_arvalid = 1'b0;
        beats(0, 1, 32'hB000_0000, 0, 8'h00, 4'h2);
        step(); step();
        chk("t3_short_pulses", 32'(lerr_cnt - base), 1);
        chk("t3_idle", 32'(busy), 0);

        // Overrun: arlen=0 but rlast on second beat -> pulse on each beat
        base = lerr_cnt;
        push_ar(1, 32'h8000_0100, 8'd0, 4'h4, 1);
        req(1, 32'h8000_0100, 8'd0, 4'h4);
        wait_ar();
        m1_arvalid = 1'b0;
        beats(1, 2, 32'hB100_0000, 1, 8'h00, 4'h4);
        step(); step();
        chk("t3_long_pulses", 32'(lerr_cnt - base), 2);
        chk("t3_long_idle", 32'(busy), 0);

        // Both masters request continuously: RR alternates m0,m1,... ; RR=0 always m1
        m0_araddr = 32'h0000_1000; m1_araddr = 32'h0000_2000;
        m0_arlen = 8'd0; m1_arlen = 8'd0; m0_arid = 4'h1; m1_arid = 4'h2;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = k[0];
            push_ar(g, g ? 32'h0000_2000 : 32'h0000_1000, 8'd0, g ? 4'h2 : 4'h1, 1);
            wait_ar();
            beats(g, 1, 32'h5000_0000 + 32'(k), 0, 8'h00, g ? 4'h2 : 4'h1);
            if (k == 3) begin
                m0_arvalid = 1'b0; m1_arvalid = 1'b0;
            end
            @(negedge clk);
            chk("t4_gap_cycle", 32'({busy, s_arvalid}), 0);
        end
        step(); step();

        // Watchdog: slave holds arready low
        s_arready = 1'b0;
        push_ar(0, 32'h3000_0100, 8'd3, 4'h5, 0);
        req(0, 32'h3000_0100, 8'd3, 4'h5);
        repeat (16) step();
        @(negedge clk);
        chk("t5_timeout_before", 32'(timeout), 0);
        step();
        @(negedge clk);
        chk("t5_timeout_at16", 32'(timeout), 1);
        repeat (3) step();
        chk("t5_timeout_sticky", 32'(timeout), 1);
        chk("t5_fsm_in_ar", 32'(busy), 1);
        chk("t5_fp_disabled", 32'(f_timeout), 0);

        // Mid-burst reset during beat 2
        s_arready = 1'b1;
        wait_ar();
        m0_arvalid = 1'b0;
        beats(0, 1, 32'hC000_0000, 99, 8'h00, 4'h5);
        s_rvalid = 1'b1; s_rdata = 32'hC000_0001; s_rid = 4'h5;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_m0_rvalid", 32'(m0_rvalid), 0);
        chk("t6_rst_m0_rdata", m0_rdata, 0);
        chk("t6_rst_s_rready", 32'(s_rready), 0);
        chk("t6_rst_timeout", 32'(timeout), 0);
        s_rvalid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        push_ar(0, 32'h0000_4000, 8'd0, 4'h6, 1);
        req(0, 32'h0000_4000, 8'd0, 4'h6);
        req(1, 32'h0000_5000, 8'd0, 4'h6);
        wait_ar();
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        beats(0, 1, 32'hE000_0000, 0, 8'h00, 4'h6);
        repeat (3) step();

        chk("end_ar_q_empty", 32'(ar_q.size()), 0);
        chk("end_r_q_empty", 32'(r_q.size()), 0);
        chk("end_fg_q_empty", 32'(fg_q.size()), 0);
        chk("end_idle_outputs", 32'(|{m0_arready, m1_arready, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
                                       m0_rresp, m1_rresp, m0_rid, m1_rid, m0_rlast, m1_rlast,
                                       s_araddr, s_arvalid, s_arid, s_arlen, s_arsize, s_arburst,
                                       s_rready, busy, grant, len_err}), 0);
        chk("end_fp_idle_outputs", 32'(|{f_m0_arready, f_m1_arready, f_m0_rdata, f_m1_rdata,
                                          f_m0_rvalid, f_m1_rvalid, f_m0_rresp, f_m1_rresp,
                                          f_m0_rid, f_m1_rid, f_m0_rlast, f_m1_rlast,
                                          f_s_araddr, f_s_arvalid, f_s_arid, f_s_arlen,
                                          f_s_arsize, f_s_arburst, f_s_rready, f_busy,
                                          f_grant, f_len_err, f_timeout}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
